flash_read_arbiter: RTL and testbench
=====================================

Name: flash_read_arbiter

Overview:
- Shares the single Avalon-MM flash read master between two requesters: requester 0 is the audio sample fetcher and requester 1 is a secondary reader such as a table or metadata loader.
- Sits between the requesters and the flash interface.
- Arbitration is round-robin, with at most one outstanding read.
- A response timeout guards against a hung flash.

Parameters:
ADDR_W, 23, flash word address width
DATA_W, 32, flash read data width
TIMEOUT, 1023, max cycles in WAIT_DATA before forced completion (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rq0_read  in  1  requester 0 read request (level, held until accepted)
rq0_address  in  ADDR_W  requester 0 address
rq0_byteenable  in  4  requester 0 byte enables
rq0_waitrequest  out  1  low = requester 0 command accepted this cycle
rq0_readdata  out  DATA_W  response data to requester 0
rq0_readdatavalid  out  1  one-cycle response strobe to requester 0
rq1_read, rq1_address, rq1_byteenable, rq1_waitrequest, rq1_readdata, rq1_readdatavalid  (same as requester 0)
flsh_read  out  1  flash read command
flsh_address  out  ADDR_W  flash address
flsh_byteenable  out  4  flash byte enables
flsh_waitrequest  in  1  flash stall
flsh_readdata  in  DATA_W  flash data
flsh_readdatavalid  in  1  flash data strobe
timeout_err  out  1  one-cycle pulse on forced completion
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (async assert, sync deassert):
  - State = IDLE, last_grant = 1 (so requester 0 wins the first tie), timeout counter = 0.
  - All outputs are 0, except rqN_waitrequest = 1.
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE:
  - If any rqN_read is high, register grant:
    - Only one requester asserting: that requester wins.
    - Both asserting: the requester ≠ last_grant wins.
  - Latch that requester's address and byteenable into the flash command registers.
  - Go to ISSUE.
- ISSUE:
  - flsh_read = 1, with the latched address and byteenable.
  - Latency: flsh_read first appears the cycle after rqN_read is sampled in IDLE.
  - While flsh_waitrequest = 1: hold the command stable and stay in ISSUE.
  - When flsh_waitrequest = 0: the command is accepted.
    - rq<grant>_waitrequest = 0 combinationally in that same cycle only. This is the requester's handshake, so it may drop rqN_read or present the next request.
    - last_grant <= grant, timeout counter cleared, go to WAIT_DATA.
    - flsh_read deasserts the next cycle.
- rqN_waitrequest is 1 in every other cycle and state.
- The losing requester's request is held pending; it is never dropped.
- WAIT_DATA:
  - Counter increments each cycle.
  - On flsh_readdatavalid = 1: register flsh_readdata into rq<grant>_readdata, pulse rq<grant>_readdatavalid the next cycle, go to IDLE. Response latency is 1 cycle after flsh_readdatavalid.
  - If the counter reaches TIMEOUT first:
    - rq<grant>_readdata = 0, with a one-cycle rq<grant>_readdatavalid.
    - timeout_err pulses in the same cycle as that strobe.
    - Go to IDLE.
  - If flsh_readdatavalid arrives on the same cycle as the timeout, the data wins and there is no error.
- readdata registers of the non-granted requester are unchanged; rqN_readdata holds its last value between strobes.
- flsh_readdatavalid seen in IDLE or ISSUE (stray or late after a timeout) is ignored: no strobe, no state change.
- Back-to-back requests: new arbitration happens in the IDLE cycle following WAIT_DATA. Minimum period is 3 cycles per read with zero waitrequest and 1-cycle flash latency.
- Requester dropping rqN_read before acceptance:
  - The latched command still completes.
  - The response is still delivered to that requester.
  - Requesters must not do this.
- Reset mid-operation: immediately returns to IDLE.
  - flsh_read drops asynchronously.
  - Any in-flight flash response after reset is ignored per the stray rule.
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- busy = (state ≠ IDLE).

Test Plan:
- Single read: rq0_read=1, addr 0x00010, flsh_waitrequest low, data 0xDEADBEEF 2 cycles after accept -> flsh_read one cycle with addr 0x00010; rq0_waitrequest low exactly the acceptance cycle; rq0_readdatavalid pulses with 0xDEADBEEF one cycle after flsh_readdatavalid; rq1 outputs unchanged.
- Contention: rq0 and rq1 both held high from reset for 4 reads -> grant order 0,1,0,1; addresses on flsh_address alternate accordingly; no request lost.
- Waitrequest stall: flsh_waitrequest high 5 cycles after ISSUE entry -> flsh_read/address/byteenable stable all 5 cycles; rqN_waitrequest high throughout; accepted on cycle 6.
- Timeout with TIMEOUT=8: flash never returns data -> 8 cycles in WAIT_DATA, then rqN_readdatavalid with data 0 and timeout_err pulse coincident; later stray flsh_readdatavalid produces no strobe.
- Data/timeout race: flsh_readdatavalid on exactly the timeout cycle with 0x12345678 -> data delivered, timeout_err stays 0.
- Reset during WAIT_DATA: rst_n low 2 cycles -> busy=0, flsh_read=0, rqN_waitrequest=1 immediately; next request starts from IDLE with requester 0 winning the tie.

Source files
------------

// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: round-robin share of one Avalon-MM flash read master between two requesters,
// one outstanding read at a time, with a response timeout against a hung flash.
module flash_read_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rq0_read,
  input  logic [ADDR_W-1:0] rq0_address,
  input  logic [3:0]        rq0_byteenable,
  output logic              rq0_waitrequest,
  output logic [DATA_W-1:0] rq0_readdata,
  output logic              rq0_readdatavalid,
  input  logic              rq1_read,
  input  logic [ADDR_W-1:0] rq1_address,
  input  logic [3:0]        rq1_byteenable,
  output logic              rq1_waitrequest,
  output logic [DATA_W-1:0] rq1_readdata,
  output logic              rq1_readdatavalid,
  output logic              flsh_read,
  output logic [ADDR_W-1:0] flsh_address,
  output logic [3:0]        flsh_byteenable,
  input  logic              flsh_waitrequest,
  input  logic [DATA_W-1:0] flsh_readdata,
  input  logic              flsh_readdatavalid,
  output logic              timeout_err,
  output logic              busy
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;
  state_t            r_state;
  logic              r_grant, r_last_grant, r_flsh_read;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_be;
  logic [DATA_W-1:0] r_rd0, r_rd1;
  logic              r_rv0, r_rv1, r_terr;
  logic              w_accept, w_win, w_done;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] w_rsp;
  assign w_accept  = r_state == ISSUE && !flsh_waitrequest;
  // On a tie the requester that was not served last wins.
  assign w_win     = (rq0_read && rq1_read) ? !r_last_grant : rq1_read;
  assign w_cnt_inc = (r_cnt == CNT_W'(TIMEOUT)) ? r_cnt : r_cnt + 1'b1;
  assign w_done    = flsh_readdatavalid || w_cnt_inc == CNT_W'(TIMEOUT);
  assign w_rsp     = flsh_readdatavalid ? flsh_readdata : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_flsh_read  <= 1'b0;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_be         <= '0;
      r_rd0        <= '0;
      r_rd1        <= '0;
      r_rv0        <= 1'b0;
      r_rv1        <= 1'b0;
      r_terr       <= 1'b0;
    end else begin
      r_rv0  <= 1'b0;
      r_rv1  <= 1'b0;
      r_terr <= 1'b0;
      case (r_state)
        IDLE: if (rq0_read || rq1_read) begin
          r_grant     <= w_win;
          r_addr      <= w_win ? rq1_address : rq0_address;
          r_be        <= w_win ? rq1_byteenable : rq0_byteenable;
          r_flsh_read <= 1'b1;
          r_state     <= ISSUE;
        end
        ISSUE: if (!flsh_waitrequest) begin
          r_last_grant <= r_grant;
          r_cnt        <= '0;
          r_flsh_read  <= 1'b0;
          r_state      <= WAIT_DATA;
        end
        WAIT_DATA: begin
          r_cnt <= w_cnt_inc;
          // Data arriving on the timeout cycle takes precedence over the error.
          if (w_done) begin
            if (r_grant) begin
              r_rd1 <= w_rsp;
              r_rv1 <= 1'b1;
            end else begin
              r_rd0 <= w_rsp;
              r_rv0 <= 1'b1;
            end
            r_terr  <= !flsh_readdatavalid;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  assign rq0_waitrequest   = !(w_accept && !r_grant);
  assign rq1_waitrequest   = !(w_accept && r_grant);
  assign rq0_readdata      = r_rd0;
  assign rq1_readdata      = r_rd1;
  assign rq0_readdatavalid = r_rv0;
  assign rq1_readdatavalid = r_rv1;
  assign flsh_read         = r_flsh_read;
  assign flsh_address      = r_addr;
  assign flsh_byteenable   = r_be;
  assign timeout_err       = r_terr;
  assign busy              = r_state != IDLE;
endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: directed scenarios plus randomized traffic checked every cycle against
// a transaction-level model of the arbiter.
module tb_flash_read_arbiter;
  localparam int AW = 23, DW = 32, TO = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic rq0_read = 1'b0, rq1_read = 1'b0;
  logic [AW-1:0] rq0_address = '0, rq1_address = '0;
  logic [3:0] rq0_byteenable = '0, rq1_byteenable = '0;
  logic rq0_waitrequest, rq1_waitrequest, rq0_readdatavalid, rq1_readdatavalid;
  logic [DW-1:0] rq0_readdata, rq1_readdata;
  logic flsh_read;
  logic [AW-1:0] flsh_address;
  logic [3:0] flsh_byteenable;
  logic flsh_waitrequest = 1'b0, flsh_readdatavalid = 1'b0;
  logic [DW-1:0] flsh_readdata = '0;
  logic timeout_err, busy;
  int checks = 0, errors = 0;

  flash_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq0_read(rq0_read), .rq0_address(rq0_address), .rq0_byteenable(rq0_byteenable),
    .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata), .rq0_readdatavalid(rq0_readdatavalid),
    .rq1_read(rq1_read), .rq1_address(rq1_address), .rq1_byteenable(rq1_byteenable),
    .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata), .rq1_readdatavalid(rq1_readdatavalid),
    .flsh_read(flsh_read), .flsh_address(flsh_address), .flsh_byteenable(flsh_byteenable),
    .flsh_waitrequest(flsh_waitrequest), .flsh_readdata(flsh_readdata), .flsh_readdatavalid(flsh_readdatavalid),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Transaction-level model: who owns the flash port, whether its command was taken,
  // how long it has waited for data, and what each requester must see.
  int m_owner = -1, m_age = 0, m_last = 1;
  bit m_acc = 0, m_terr = 0;
  bit m_rv [2] = '{0, 0};
  logic [DW-1:0] m_rd [2] = '{'0, '0};
  logic [AW-1:0] m_addr = '0;
  logic [3:0] m_be = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_acc = 0; m_age = 0; m_last = 1; m_addr = '0; m_be = '0;
      m_rd[0] = '0; m_rd[1] = '0; m_rv[0] = 0; m_rv[1] = 0; m_terr = 0;
    end else begin
      m_rv[0] = 0; m_rv[1] = 0; m_terr = 0;
      if (m_owner < 0) begin
        if (rq0_read || rq1_read) begin
          m_owner = (rq0_read && rq1_read) ? 1 - m_last : (rq1_read ? 1 : 0);
          m_acc = 0;
          m_addr = (m_owner == 1) ? rq1_address : rq0_address;
          m_be = (m_owner == 1) ? rq1_byteenable : rq0_byteenable;
        end
      end else if (!m_acc) begin
        if (!flsh_waitrequest) begin
          m_acc = 1; m_last = m_owner; m_age = 0;
        end
      end else begin
        m_age++;
        if (flsh_readdatavalid || m_age == TO) begin
          m_rd[m_owner] = flsh_readdatavalid ? flsh_readdata : '0;
          m_rv[m_owner] = 1;
          m_terr = !flsh_readdatavalid;
          m_owner = -1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_owner >= 0);
    chk("flsh_read", flsh_read, m_owner >= 0 && !m_acc);
    chk("flsh_address", flsh_address, m_addr);
    chk("flsh_byteenable", flsh_byteenable, m_be);
    chk("rq0_waitrequest", rq0_waitrequest, !(m_owner == 0 && !m_acc && !flsh_waitrequest));
    chk("rq1_waitrequest", rq1_waitrequest, !(m_owner == 1 && !m_acc && !flsh_waitrequest));
    chk("rq0_readdatavalid", rq0_readdatavalid, m_rv[0]);
    chk("rq1_readdatavalid", rq1_readdatavalid, m_rv[1]);
    chk("rq0_readdata", rq0_readdata, m_rd[0]);
    chk("rq1_readdata", rq1_readdata, m_rd[1]);
    chk("timeout_err", timeout_err, m_terr);
  end

  int na = 0, nacc = 0, nto = 0, rst_hold = 0;
  bit pend = 0, g0 = 0, g1 = 0, acc0 = 0, acc1 = 0;
  int ord [4] = '{-1, -1, -1, -1};
  logic [AW-1:0] adr [4];

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_flsh_read", flsh_read, 0);
    chk("rst_rq0_wr", rq0_waitrequest, 1);
    chk("rst_rq1_wr", rq1_waitrequest, 1);
    chk("rst_terr", timeout_err, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    // single read
    nxt; rq0_read = 1; rq0_address = 23'h00010; rq0_byteenable = 4'hF; smp;
    chk("t1_idle_busy", busy, 0);
    nxt; smp;
    chk("t1_flsh_read", flsh_read, 1);
    chk("t1_addr", flsh_address, 23'h10);
    chk("t1_rq0_accept", rq0_waitrequest, 0);
    chk("t1_rq1_wr", rq1_waitrequest, 1);
    nxt; rq0_read = 0; smp;
    chk("t1_flsh_read_off", flsh_read, 0);
    chk("t1_rq0_wr_back", rq0_waitrequest, 1);
    nxt; flsh_readdatavalid = 1; flsh_readdata = 32'hDEADBEEF; smp;
    chk("t1_no_early_strobe", rq0_readdatavalid, 0);
    nxt; flsh_readdatavalid = 0; smp;
    chk("t1_strobe", rq0_readdatavalid, 1);
    chk("t1_data", rq0_readdata, 32'hDEADBEEF);
    chk("t1_rq1_rv", rq1_readdatavalid, 0);
    chk("t1_rq1_rd", rq1_readdata, 0);
    nxt; smp;
    chk("t1_strobe_once", rq0_readdatavalid, 0);
    // contention from reset
    #1 rst_n = 1'b0;
    rq0_read = 1; rq1_read = 1; rq0_address = 23'h100; rq1_address = 23'h200;
    rq0_byteenable = 4'h3; rq1_byteenable = 4'hC;
    #1 chk("t2_rst_clears_data", rq0_readdata, 0);
    nxt; nxt; rst_n = 1'b1;
    for (int c = 0; c < 60 && na < 4; c++) begin
      nxt;
      flsh_readdatavalid = pend; flsh_readdata = $urandom;
      if (g0) rq0_address = rq0_address + 23'd4;
      if (g1) rq1_address = rq1_address + 23'd4;
      smp;
      pend = flsh_read && !flsh_waitrequest;
      g0 = !rq0_waitrequest; g1 = !rq1_waitrequest;
      if (g0 || g1) begin
        ord[na] = g1 ? 1 : 0; adr[na] = flsh_address; na++;
      end
    end
    chk("t2_count", 64'(na), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_grant%0d", i), 64'(ord[i]), 64'(i % 2));
      chk($sformatf("t2_addr%0d", i), adr[i], ((i % 2) != 0 ? 64'h200 : 64'h100) + 64'(4 * (i / 2)));
    end
    nxt; rq0_read = 0; rq1_read = 0; flsh_readdatavalid = pend; smp;
    nxt; flsh_readdatavalid = 0; smp;
    // waitrequest stall
    nxt; rq1_read = 1; rq1_address = 23'h3ABCD; rq1_byteenable = 4'h5; flsh_waitrequest = 1; smp;
    for (int k = 0; k < 5; k++) begin
      nxt; smp;
      chk("t3_read", flsh_read, 1);
      chk("t3_addr", flsh_address, 23'h3ABCD);
      chk("t3_be", flsh_byteenable, 4'h5);
      chk("t3_wr", rq1_waitrequest, 1);
    end
    nxt; flsh_waitrequest = 0; smp;
    chk("t3_accept", rq1_waitrequest, 0);
    chk("t3_rq0_wr", rq0_waitrequest, 1);
    nxt; rq1_read = 0; flsh_readdatavalid = 1; flsh_readdata = 32'hCAFEF00D; smp;
    nxt; flsh_readdatavalid = 0; smp;
    chk("t3_strobe", rq1_readdatavalid, 1);
    chk("t3_data", rq1_readdata, 32'hCAFEF00D);
    chk("t3_rq0_rv", rq0_readdatavalid, 0);
    // timeout
    nxt; rq0_read = 1; rq0_address = 23'h55; rq0_byteenable = 4'hF; smp;
    nxt; smp;
    chk("t4_accept", rq0_waitrequest, 0);
    for (int k = 0; k < TO; k++) begin
      nxt; rq0_read = 0; smp;
      chk("t4_wait_busy", busy, 1);
      chk("t4_no_strobe", rq0_readdatavalid, 0);
      chk("t4_no_err", timeout_err, 0);
    end
    nxt; smp;
    chk("t4_strobe", rq0_readdatavalid, 1);
    chk("t4_data0", rq0_readdata, 0);
    chk("t4_err", timeout_err, 1);
    chk("t4_idle", busy, 0);
    nxt; flsh_readdatavalid = 1; flsh_readdata = 32'hBAD0BAD0; smp;
    chk("t4_err_once", timeout_err, 0);
    nxt; flsh_readdatavalid = 0; smp;
    chk("t4_stray_ignored", rq0_readdatavalid, 0);
    chk("t4_stray_data", rq0_readdata, 0);
    // data on the timeout cycle
    nxt; rq1_read = 1; rq1_address = 23'h77; smp;
    nxt; smp;
    chk("t5_accept", rq1_waitrequest, 0);
    for (int k = 0; k < TO; k++) begin
      nxt; rq1_read = 0; flsh_readdatavalid = (k == TO - 1); flsh_readdata = 32'h12345678; smp;
    end
    nxt; flsh_readdatavalid = 0; smp;
    chk("t5_strobe", rq1_readdatavalid, 1);
    chk("t5_data", rq1_readdata, 32'h12345678);
    chk("t5_no_err", timeout_err, 0);
    // reset during WAIT_DATA
    nxt; rq0_read = 1; rq0_address = 23'h99; smp;
    nxt; smp;
    nxt; rq0_read = 0; smp;
    chk("t6_busy_before", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_flsh_read", flsh_read, 0);
    chk("t6_rq0_wr", rq0_waitrequest, 1);
    chk("t6_rq1_wr", rq1_waitrequest, 1);
    nxt; nxt; rst_n = 1'b1;
    rq0_read = 1; rq1_read = 1; rq0_address = 23'h0AA; rq1_address = 23'h0BB; flsh_readdatavalid = 1;
    smp;
    chk("t6_idle", busy, 0);
    nxt; flsh_readdatavalid = 0; smp;
    chk("t6_flsh_read", flsh_read, 1);
    chk("t6_tie_rq0", flsh_address, 23'h0AA);
    chk("t6_rq0_accept", rq0_waitrequest, 0);
    chk("t6_stray_ignored", rq0_readdatavalid, 0);
    nxt; rq0_read = 0; smp;
    // randomized traffic
    acc0 = 0; acc1 = !rq1_waitrequest;
    for (int c = 0; c < 4000; c++) begin
      nxt;
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if ($urandom_range(499) == 0) begin
        rst_n = 1'b0; rst_hold = 2;
      end
      if (!rq0_read || acc0) begin
        rq0_read = rq0_read ? ($urandom_range(1) == 1) : ($urandom_range(2) == 0);
        rq0_address = AW'($urandom); rq0_byteenable = 4'($urandom);
      end
      if (!rq1_read || acc1) begin
        rq1_read = rq1_read ? ($urandom_range(1) == 1) : ($urandom_range(2) == 0);
        rq1_address = AW'($urandom); rq1_byteenable = 4'($urandom);
      end
      flsh_waitrequest = ($urandom_range(2) == 0);
      flsh_readdatavalid = ($urandom_range(3) == 0);
      flsh_readdata = $urandom;
      smp;
      acc0 = !rq0_waitrequest; acc1 = !rq1_waitrequest;
      if (acc0 || acc1) nacc++;
      if (timeout_err) nto++;
    end
    rst_n = 1'b1;
    chk("rand_accepts", 64'(nacc > 100), 1);
    chk("rand_timeouts", 64'(nto > 0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
